// File: rtl/npc_pkg.sv
// Shared types and constants for the npc core front end.
package npc_pkg;

  // PC loaded when the core comes out of reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // addi x0, x0, 0 -- bubble instruction for downstream stages.
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Fetch unit states.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } ifu_state_t;

  // Instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: owns the architectural PC, fetches one word at a
// time from instruction memory and hands it to execute, which returns the
// successor PC on acceptance.
module ifu
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic [31:0] next_pc,
  output logic        fetch_fault
);

  ifu_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  // State, PC and instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  // Next-state, next-PC and instruction capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      S_REQ: begin
        // Request stays up with a stable address until memory takes it.
        if (imem_req_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            // pc keeps the address whose fetch failed.
            state_d = S_FAULT;
          end else begin
            inst_d  = imem_rsp_data;
            state_d = S_HOLD;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        // next_pc is only meaningful on the accepting cycle.
        if (inst_ready) begin
          pc_d    = next_pc;
          state_d = is_misaligned(next_pc) ? S_FAULT : S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Handshake and status outputs decoded from state only.
  always_comb begin
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    fetch_fault    = 1'b0;
    case (state_q)
      // Reset parks the FSM in S_REQ, so the request is masked while held.
      S_REQ:   imem_req_valid = rst_n;
      S_WAIT:  imem_req_valid = 1'b0;
      S_HOLD:  inst_valid     = 1'b1;
      S_FAULT: fetch_fault    = 1'b1;
      default: imem_req_valid = 1'b0;
    endcase
  end

  assign imem_req_addr = pc_q;
  assign inst          = inst_q;
  assign inst_pc       = pc_q;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: a memory model answers one cycle after each
// accepted request, a monitor logs request and instruction handshakes, and
// each test compares those logs against expectations it queued itself.
module tb_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] next_pc;
  logic        fetch_fault;

  // Execute model: sequential unless the current PC matches a jump source.
  logic [31:0] jmp1_src, jmp1_dst, jmp2_src, jmp2_dst;
  assign next_pc = (inst_pc == jmp1_src) ? jmp1_dst :
                   (inst_pc == jmp2_src) ? jmp2_dst : inst_pc + 32'd4;

  // Memory model controls.
  logic        err_en;
  logic [31:0] err_addr;
  int          stray_req;

  // Monitor state and logs (written only by the monitor process).
  bit          acc_pend;
  logic [31:0] acc_addr;
  int          stray_done;
  int          cyc;
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] hs_inst[$];
  logic [31:0] hs_pc[$];
  int          hs_cyc[$];

  // Scoreboard of expected request addresses and instruction words.
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];

  int n_checks;
  int n_fail;

  ifu #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .next_pc        (next_pc),
    .fetch_fault    (fetch_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: reset vector holds auipc t0,0; other words derive from the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RST_PC) return 32'h0000_0297;
    return (a ^ 32'h5A5A_0000) | 32'h0000_0003;
  endfunction

  // Memory responder and handshake monitor: drive at negedge, sample 1 time unit later.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    imem_rsp_data  = 32'h0;
    acc_pend       = 1'b0;
    acc_addr       = 32'h0;
    stray_done     = 0;
    cyc            = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        acc_pend = 1'b0;
        stray_done = stray_req;
        imem_rsp_valid = 1'b0;
        imem_rsp_err = 1'b0;
        imem_rsp_data = 32'h0;
        req_log.delete(); req_cyc.delete();
        hs_inst.delete(); hs_pc.delete(); hs_cyc.delete();
      end else if (acc_pend) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(acc_addr);
        imem_rsp_err   = err_en && (acc_addr == err_addr);
        acc_pend       = 1'b0;
      end else if (stray_done != stray_req) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        imem_rsp_err   = 1'b0;
        stray_done     = stray_req;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
      end
      #1;
      if (rst_n && imem_req_valid && imem_req_ready) begin
        acc_pend = 1'b1;
        acc_addr = imem_req_addr;
        req_log.push_back(imem_req_addr);
        req_cyc.push_back(cyc);
      end
      if (rst_n && inst_valid && inst_ready) begin
        hs_inst.push_back(inst);
        hs_pc.push_back(inst_pc);
        hs_cyc.push_back(cyc);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (req_log.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk); #2;
    end
  endtask

  task automatic wait_hs(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (hs_inst.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk); #2;
    end
  endtask

  task automatic test_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid: got %b expected 0", inst_valid); end
    n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b expected 0", fetch_fault); end
    n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h expected 00000000", inst); end
    n_checks++; if (inst_pc !== RST_PC) begin n_fail++; $display("FAIL rst_inst_pc: got %h expected %h", inst_pc, RST_PC); end
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_valid: got %b expected 1", imem_req_valid); end
    n_checks++; if (imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL first_req_addr: got %h expected %h", imem_req_addr, RST_PC); end
  endtask

  // Continues straight from test_reset: zero-wait memory, execute always ready.
  task automatic test_stream();
    bit ok;
    logic [31:0] a, w;
    exp_addr_q.delete(); exp_inst_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_addr_q.push_back(RST_PC + 32'(i) * 32'd4);
      exp_inst_q.push_back(mem_word(RST_PC + 32'(i) * 32'd4));
    end
    wait_hs(4, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stream_timeout: got %0d instructions expected 4", hs_inst.size()); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        a = exp_addr_q.pop_front();
        w = exp_inst_q.pop_front();
        n_checks++; if (req_log[i] !== a) begin n_fail++; $display("FAIL stream_addr%0d: got %h expected %h", i, req_log[i], a); end
        n_checks++; if (hs_pc[i] !== a) begin n_fail++; $display("FAIL stream_pc%0d: got %h expected %h", i, hs_pc[i], a); end
        n_checks++; if (hs_inst[i] !== w) begin n_fail++; $display("FAIL stream_inst%0d: got %h expected %h", i, hs_inst[i], w); end
      end
      n_checks++; if (hs_cyc[0] - req_cyc[0] != 2) begin n_fail++; $display("FAIL first_latency: got %0d expected 2", hs_cyc[0] - req_cyc[0]); end
      for (int i = 1; i < 4; i++) begin
        n_checks++; if (req_cyc[i] - req_cyc[i-1] != 3) begin n_fail++; $display("FAIL stream_spacing%0d: got %0d expected 3", i, req_cyc[i] - req_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL bp_req_valid%0d: got %b expected 1", i, imem_req_valid); end
      n_checks++; if (imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL bp_req_addr%0d: got %h expected %h", i, imem_req_addr, RST_PC); end
    end
    n_checks++; if (req_log.size() != 0) begin n_fail++; $display("FAIL bp_no_accept: got %0d expected 0", req_log.size()); end
    @(negedge clk); imem_req_ready = 1'b1;
    @(negedge clk); imem_req_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid%0d: got %b expected 1", i, inst_valid); end
      n_checks++; if (inst !== 32'h0000_0297) begin n_fail++; $display("FAIL hold_inst%0d: got %h expected 00000297", i, inst); end
      n_checks++; if (inst_pc !== RST_PC) begin n_fail++; $display("FAIL hold_pc%0d: got %h expected %h", i, inst_pc, RST_PC); end
      n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL hold_no_req%0d: got %b expected 0", i, imem_req_valid); end
    end
    n_checks++; if (req_log.size() != 1) begin n_fail++; $display("FAIL bp_one_request: got %0d expected 1", req_log.size()); end
    @(negedge clk);
    inst_ready = 1'b1;
    imem_req_ready = 1'b1;
    exp_addr_q.delete();
    exp_addr_q.push_back(RST_PC + 32'd4);
    wait_req(2, ok);
    n_checks++; if (!ok || req_log[1] !== exp_addr_q[0]) begin n_fail++; $display("FAIL bp_release_addr: got %h expected %h", ok ? req_log[1] : 32'hx, exp_addr_q[0]); end
    void'(exp_addr_q.pop_front());
  endtask

  task automatic test_jump_misalign();
    bit ok;
    logic [31:0] a;
    jmp1_src = RST_PC;          jmp1_dst = 32'h8000_0100;
    jmp2_src = 32'h8000_0100;   jmp2_dst = 32'h8000_0102;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    exp_addr_q.delete();
    exp_addr_q.push_back(RST_PC);
    exp_addr_q.push_back(32'h8000_0100);
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #2;
      if (fetch_fault === 1'b1) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL misalign_fault: got %b expected 1", fetch_fault); end
    repeat (6) @(negedge clk);
    #2;
    n_checks++; if (req_log.size() != 2) begin n_fail++; $display("FAIL jump_req_count: got %0d expected 2", req_log.size()); end
    for (int i = 0; i < 2; i++) begin
      a = exp_addr_q.pop_front();
      n_checks++; if (req_log.size() <= i || req_log[i] !== a) begin n_fail++; $display("FAIL jump_addr%0d: got %h expected %h", i, (req_log.size() > i) ? req_log[i] : 32'hx, a); end
    end
    n_checks++; if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL fault_sticky: got %b expected 1", fetch_fault); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL fault_req_valid: got %b expected 0", imem_req_valid); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL fault_inst_valid: got %b expected 0", inst_valid); end
    n_checks++; if (imem_req_addr !== 32'h8000_0102) begin n_fail++; $display("FAIL fault_pc: got %h expected 80000102", imem_req_addr); end
    jmp1_src = 32'h0000_0001;
    jmp2_src = 32'h0000_0001;
  endtask

  task automatic test_mem_error();
    bit ok;
    err_en   = 1'b1;
    err_addr = RST_PC;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #2;
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL err_inst_valid%0d: got %b expected 0", i, inst_valid); end
      if (fetch_fault === 1'b1) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL err_fault: got %b expected 1", fetch_fault); end
    repeat (4) @(negedge clk);
    #2;
    n_checks++; if (hs_inst.size() != 0) begin n_fail++; $display("FAIL err_no_inst: got %0d expected 0", hs_inst.size()); end
    n_checks++; if (req_log.size() != 1) begin n_fail++; $display("FAIL err_req_count: got %0d expected 1", req_log.size()); end
    n_checks++; if (imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL err_pc: got %h expected %h", imem_req_addr, RST_PC); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL err_req_valid: got %b expected 0", imem_req_valid); end
    err_en = 1'b0;
  endtask

  task automatic test_stray_rsp();
    bit ok;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #2;
      if (inst_valid === 1'b1) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stray_hold_reached: got %b expected 1", inst_valid); end
    stray_req++;
    repeat (3) @(negedge clk);
    #2;
    n_checks++; if (inst !== 32'h0000_0297) begin n_fail++; $display("FAIL stray_inst: got %h expected 00000297", inst); end
    n_checks++; if (inst_pc !== RST_PC) begin n_fail++; $display("FAIL stray_pc: got %h expected %h", inst_pc, RST_PC); end
    n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL stray_valid: got %b expected 1", inst_valid); end
    n_checks++; if (req_log.size() != 1) begin n_fail++; $display("FAIL stray_req_count: got %0d expected 1", req_log.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    do_reset();
    wait_req(3, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_setup: got %0d requests expected 3", req_log.size()); end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_req_valid: got %b expected 0", imem_req_valid); end
    n_checks++; if (imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL mid_req_addr: got %h expected %h", imem_req_addr, RST_PC); end
    n_checks++; if (inst_pc !== RST_PC) begin n_fail++; $display("FAIL mid_inst_pc: got %h expected %h", inst_pc, RST_PC); end
    n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL mid_inst: got %h expected 00000000", inst); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL mid_inst_valid: got %b expected 0", inst_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_hs(1, ok);
    n_checks++; if (!ok || req_log[0] !== RST_PC) begin n_fail++; $display("FAIL mid_restart_addr: got %h expected %h", ok ? req_log[0] : 32'hx, RST_PC); end
    n_checks++; if (!ok || hs_inst[0] !== 32'h0000_0297) begin n_fail++; $display("FAIL mid_restart_inst: got %h expected 00000297", ok ? hs_inst[0] : 32'hx); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    imem_req_ready = 1'b0;
    inst_ready = 1'b0;
    err_en   = 1'b0;
    err_addr = 32'h0;
    stray_req = 0;
    jmp1_src = 32'h0000_0001; jmp1_dst = 32'h0;
    jmp2_src = 32'h0000_0001; jmp2_dst = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_jump_misalign();
    test_mem_error();
    test_stray_rsp();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
